times_table_read_arbiter: RTL and testbench
===========================================

TIMES_TABLE_READ_ARBITER -- requirements
Module: times_table_read_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum cycles from grant to read-data before abort.
REQ-002 Parameter: BASE_ADDR, 32'h0000_0000, byte base of the times-table memory.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 req0, req1  in  1  requester read request, level, held until ackN.
REQ-006 a0, b0, a1, b1  in  3  multiplicand operands per requester.
REQ-007 ack0, ack1  out  1  one-cycle completion pulse per requester.
REQ-008 result0, result1  out  6  product returned to requester; holds its value until the next ack to the same requester.
REQ-009 err0, err1  out  1  valid with ackN; 1 = SLVERR/DECERR or timeout.
REQ-010 m_araddr  out  32  AXI4-Lite read address.
REQ-011 m_arvalid  out  1; m_arready  in  1  AR handshake.
REQ-012 m_rdata  in  32; m_rresp  in  2; m_rvalid  in  1; m_rready  out  1  R channel.

Function
REQ-013 The FSM SHALL have states IDLE, ADDR, DATA, DONE; one transaction in flight at a time.
REQ-014 IDLE: when any reqN=1, the block SHALL grant one requester, latch its a/b, and enter ADDR next cycle.
REQ-015 Arbitration SHALL be round-robin: with both requesting, the requester not granted last wins; after reset req0 wins the first tie.
REQ-016 m_araddr SHALL be BASE_ADDR + {a,b,2'b00}, where a/b are the latched operands, i.e. word index a*8+b.
REQ-017 ADDR: m_arvalid=1 with m_araddr stable until m_arvalid&m_arready; then m_arvalid=0 and DATA next cycle.
REQ-018 DATA: m_rready=1; on m_rvalid, latch result=m_rdata[5:0] and err=(m_rresp!=2'b00), then DONE.
REQ-019 DONE: ackN of the granted requester=1 for exactly one cycle, resultN/errN updated that cycle, then IDLE.
REQ-020 Minimum latency with arready and rvalid each asserted the cycle they are first sampled: req sampled in cycle 0 -> ack in cycle 3.
REQ-021 A timeout counter SHALL start at grant; if DATA is not left after TIMEOUT cycles, the block SHALL deassert arvalid/rready, go to DONE with err=1, result=6'd0.
REQ-022 reqN deasserted after grant SHALL NOT abort the transaction; requests are only sampled in IDLE.
REQ-023 The block SHALL NOT assert ack0 and ack1 in the same cycle; a requester SHALL NOT be re-granted in the cycle following its ack (IDLE is visited for at least one cycle).
REQ-024 m_rdata[31:6] SHALL be ignored.

Reset
REQ-025 With rst=0 at a clock edge: FSM=IDLE, m_arvalid=0, m_rready=0, m_araddr=0, ack0/1=0, result0/1=0, err0/1=0, timeout counter=0, last-grant=req1.
REQ-026 Reset mid-transaction SHALL abort it with no ack issued; the first post-reset grant follows REQ-015.

Structure
REQ-027 Package times_table_pkg SHALL hold the state enum, RESP_OKAY=2'b00, operand width 3, result width 6.
REQ-028 One sub-module rr_arb2 (2-way round-robin grant with last-grant register) SHALL be instantiated; remaining logic flat.

Verification
REQ-029 req0, a0=3, b0=5, memory returns 15, arready/rvalid immediate -> araddr=0x74, ack0 in cycle 3, result0=6'd15, err0=0.
REQ-030 req0 and req1 together from reset (a0=2,b0=2; a1=7,b1=7) -> ack0 first with result0=4, then ack1 with result1=49; never both acks in the same cycle.
REQ-031 arready withheld 4 cycles -> arvalid held high with araddr stable throughout; completes normally.
REQ-032 rvalid never asserted, TIMEOUT=16 -> ackN pulses with errN=1, resultN=0; block returns to IDLE.
REQ-033 rresp=2'b10 with rdata=9 -> ackN with errN=1, resultN=9.
REQ-034 rst=0 asserted during DATA -> next cycle all outputs 0, no ack; new req0 then completes normally.

Source files
------------

// File: rtl/times_table_pkg.sv
// Shared types and constants for the times-table read arbiter.
package times_table_pkg;

  localparam int OPW  = 3;
  localparam int RESW = 6;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/times_table_read_arbiter_rr_arb2.sv
// Two-way round-robin grant; the requester not granted last wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  // 1 = requester 1 was granted last, so requester 0 wins the first tie
  logic last_reg;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_reg)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_reg <= 1'b1;
    end else if (take && (gnt != 2'b00)) begin
      last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/times_table_read_arbiter.sv
// Arbitrates two product lookups onto one AXI4-Lite read master, one transaction
// in flight, with a grant-to-data timeout that completes the request with an error.
module times_table_read_arbiter #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  a0,
  input  logic [2:0]  b0,
  input  logic [2:0]  a1,
  input  logic [2:0]  b1,
  output logic        ack0,
  output logic        ack1,
  output logic [5:0]  result0,
  output logic [5:0]  result1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);
  import times_table_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic            sel_reg;
  logic [31:0]     addr_reg;
  logic [TW-1:0]   timer_reg;
  logic [RESW-1:0] result0_reg, result1_reg;
  logic            err0_reg, err1_reg;

  logic [1:0]      gnt;
  logic            take;
  logic            expired;
  logic            finish;
  logic [OPW-1:0]  op_a, op_b;
  logic [RESW-1:0] fin_res;
  logic            fin_err;
  logic            unused_rdata;

  assign unused_rdata = ^m_rdata[31:RESW];

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({req1, req0}),
    .take (take),
    .gnt  (gnt)
  );

  assign take    = (state_reg == IDLE);
  assign expired = (timer_reg >= TLIM);
  assign op_a    = gnt[1] ? a1 : a0;
  assign op_b    = gnt[1] ? b1 : b0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (gnt != 2'b00) state_next = ADDR;
      ADDR: begin
        if (m_arready)    state_next = DATA;
        else if (expired) state_next = DONE;
      end
      DATA: if (m_rvalid || expired) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A timed-out request completes as an error with a zero product
  always_comb begin
    finish  = ((state_reg == ADDR) || (state_reg == DATA)) && (state_next == DONE);
    fin_res = '0;
    fin_err = 1'b1;
    if ((state_reg == DATA) && m_rvalid) begin
      fin_res = m_rdata[RESW-1:0];
      fin_err = (m_rresp != RESP_OKAY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_reg     <= 1'b0;
      addr_reg    <= '0;
      timer_reg   <= '0;
      result0_reg <= '0;
      result1_reg <= '0;
      err0_reg    <= 1'b0;
      err1_reg    <= 1'b0;
    end else begin
      if (take && (gnt != 2'b00)) begin
        sel_reg   <= gnt[1];
        addr_reg  <= BASE_ADDR + {24'b0, op_a, op_b, 2'b00};
        timer_reg <= '0;
      end else if ((state_reg == ADDR) || (state_reg == DATA)) begin
        timer_reg <= timer_reg + TW'(1);
      end
      if (finish) begin
        if (sel_reg) begin
          result1_reg <= fin_res;
          err1_reg    <= fin_err;
        end else begin
          result0_reg <= fin_res;
          err0_reg    <= fin_err;
        end
      end
    end
  end

  assign m_arvalid = (state_reg == ADDR);
  assign m_rready  = (state_reg == DATA);
  assign m_araddr  = addr_reg;
  assign ack0      = (state_reg == DONE) && !sel_reg;
  assign ack1      = (state_reg == DONE) && sel_reg;
  assign result0   = result0_reg;
  assign result1   = result1_reg;
  assign err0      = err0_reg;
  assign err1      = err1_reg;

endmodule

// File: tb/tb_times_table_read_arbiter.sv
// Directed bench: AXI4-Lite memory responder returning a*b, table of single
// transactions plus hand-written tie, stall, timeout and reset sequences.
module tb_times_table_read_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  a0, b0, a1, b1;
  logic        ack0, ack1;
  logic [5:0]  result0, result1;
  logic        err0, err1;
  logic [31:0] m_araddr;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid, m_rready;

  times_table_read_arbiter #(.TIMEOUT(TIMEOUT), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result0(result0), .result1(result1),
    .err0(err0), .err1(err1),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // responder knobs and observations
  int          ar_wait, r_wait;
  logic        r_never, ovr_en;
  logic [31:0] ovr_data;
  logic [1:0]  rresp_val;
  logic [31:0] last_araddr;
  logic        both_ack, ar_bad;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // AXI4-Lite slave: memory word at index a*8+b holds a*b with junk upper bits
  initial begin : responder
    int          ar_cnt, r_cnt;
    logic        ar_pend;
    logic [31:0] ar_prev;
    logic [5:0]  idx;
    logic [2:0]  ma, mb;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    ar_cnt = 0; r_cnt = 0; ar_pend = 0; ar_prev = 0;
    forever begin
      @(negedge clk);
      if (ack0 && ack1) both_ack = 1'b1;
      if (ar_pend && (!m_arvalid || m_araddr != ar_prev)) ar_bad = 1'b1;
      if (!rst) begin
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        ar_cnt = 0; r_cnt = 0; ar_pend = 0;
      end else begin
        if (m_arvalid && ar_cnt >= ar_wait) begin
          m_arready = 1'b1;
          last_araddr = m_araddr;
        end else begin
          m_arready = 1'b0;
          ar_cnt = m_arvalid ? ar_cnt + 1 : 0;
        end
        ar_pend = m_arvalid && !m_arready;
        ar_prev = m_araddr;
        if (m_rready && !r_never && r_cnt >= r_wait) begin
          idx = m_araddr[7:2];
          ma = idx[5:3];
          mb = idx[2:0];
          m_rvalid = 1'b1;
          m_rdata  = ovr_en ? ovr_data : {26'h2AA_AAAA, 6'(ma * mb)};
          m_rresp  = rresp_val;
        end else begin
          m_rvalid = 1'b0;
          m_rdata  = 32'h0;
          m_rresp  = 2'b00;
          r_cnt = m_rready ? r_cnt + 1 : 0;
        end
      end
    end
  end

  // counts negedges until an ack; lat = -1 if none within limit
  task automatic wait_ack(input int limit, output int lat, output logic [1:0] acks);
    lat = -1;
    acks = 2'b00;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        lat = i;
        acks = {ack1, ack0};
        break;
      end
    end
  endtask

  typedef struct {
    logic        sel;
    logic [2:0]  a, b;
    logic        ovr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] exp_addr;
    logic [5:0]  exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];
  logic [5:0] held[2];

  int         lat;
  logic [1:0] acks;

  initial begin : main
    vecs[0] = '{1'b0, 3'd3, 3'd5, 1'b0, 32'h0,         2'b00, 32'h74, 6'd15, 1'b0};
    vecs[1] = '{1'b1, 3'd7, 3'd7, 1'b0, 32'h0,         2'b00, 32'hFC, 6'd49, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 3'd0, 1'b0, 32'h0,         2'b00, 32'h00, 6'd0,  1'b0};
    vecs[3] = '{1'b1, 3'd7, 3'd1, 1'b0, 32'h0,         2'b00, 32'hE4, 6'd7,  1'b0};
    vecs[4] = '{1'b0, 3'd2, 3'd3, 1'b1, 32'h9,         2'b10, 32'h4C, 6'd9,  1'b1};
    vecs[5] = '{1'b1, 3'd1, 3'd6, 1'b1, 32'hFFFF_FFC5, 2'b11, 32'h38, 6'd5,  1'b1};
    vecs[6] = '{1'b0, 3'd4, 3'd4, 1'b0, 32'h0,         2'b01, 32'h90, 6'd16, 1'b1};

    ar_wait = 0; r_wait = 0; r_never = 0; ovr_en = 0; ovr_data = 0; rresp_val = 0;
    last_araddr = 0; both_ack = 0; ar_bad = 0;
    rst = 0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (3) @(negedge clk);

    check("rst_acks",    {30'b0, ack1, ack0}, 32'h0);
    check("rst_results", {20'b0, result1, result0}, 32'h0);
    check("rst_errs",    {30'b0, err1, err0}, 32'h0);
    check("rst_axi",     {30'b0, m_arvalid, m_rready}, 32'h0);
    check("rst_araddr",  m_araddr, 32'h0);
    rst = 1;
    @(negedge clk);

    // tie straight out of reset: req0 first, then req1 after one IDLE cycle
    a0 = 3'd2; b0 = 3'd2; a1 = 3'd7; b1 = 3'd7;
    req0 = 1; req1 = 1;
    wait_ack(40, lat, acks);
    check("tie0_first_ack", {30'b0, acks}, 32'h1);
    check("tie0_first_lat", lat, 3);
    check("tie0_result0", {26'b0, result0}, 32'd4);
    req0 = 0;
    wait_ack(40, lat, acks);
    check("tie0_second_ack", {30'b0, acks}, 32'h2);
    check("tie0_second_lat", lat, 4);
    check("tie0_result1", {26'b0, result1}, 32'd49);
    req1 = 0;
    $display("txn tie-from-reset: ack0 result0=%0d then ack1 result1=%0d", result0, result1);
    held[0] = 6'd4;
    held[1] = 6'd49;

    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      ovr_en = vecs[v].ovr; ovr_data = vecs[v].rdata; rresp_val = vecs[v].rresp;
      if (vecs[v].sel) begin a1 = vecs[v].a; b1 = vecs[v].b; req1 = 1; end
      else begin a0 = vecs[v].a; b0 = vecs[v].b; req0 = 1; end
      wait_ack(40, lat, acks);
      req0 = 0; req1 = 0;
      held[vecs[v].sel] = vecs[v].exp_res;
      check($sformatf("vec%0d_ack", v), {30'b0, acks}, vecs[v].sel ? 32'h2 : 32'h1);
      check($sformatf("vec%0d_lat", v), lat, 3);
      check($sformatf("vec%0d_addr", v), last_araddr, vecs[v].exp_addr);
      check($sformatf("vec%0d_result", v), {26'b0, vecs[v].sel ? result1 : result0}, {26'b0, vecs[v].exp_res});
      check($sformatf("vec%0d_err", v), {31'b0, vecs[v].sel ? err1 : err0}, {31'b0, vecs[v].exp_err});
      @(negedge clk);
      check($sformatf("vec%0d_hold", v), {20'b0, result1, result0}, {20'b0, held[1], held[0]});
      $display("txn vec%0d: req%0d a=%0d b=%0d araddr=%0h result=%0d lat=%0d",
               v, vecs[v].sel, vecs[v].a, vecs[v].b, last_araddr,
               vecs[v].sel ? result1 : result0, lat);
    end
    ovr_en = 0; rresp_val = 0;

    // req0 was granted last, so req1 wins this tie
    a0 = 3'd3; b0 = 3'd3; a1 = 3'd1; b1 = 3'd2;
    req0 = 1; req1 = 1;
    wait_ack(40, lat, acks);
    check("tie1_first_ack", {30'b0, acks}, 32'h2);
    check("tie1_result1", {26'b0, result1}, 32'd2);
    req1 = 0;
    wait_ack(40, lat, acks);
    check("tie1_second_ack", {30'b0, acks}, 32'h1);
    check("tie1_second_lat", lat, 4);
    check("tie1_result0", {26'b0, result0}, 32'd9);
    req0 = 0;
    check("never_both_acks", {31'b0, both_ack}, 32'h0);
    $display("txn tie-after-req0: ack1 result1=%0d then ack0 result0=%0d", result1, result0);

    // AR stalled four cycles
    @(negedge clk);
    ar_wait = 4; ar_bad = 0;
    a0 = 3'd5; b0 = 3'd6; req0 = 1;
    wait_ack(40, lat, acks);
    req0 = 0;
    ar_wait = 0;
    check("stall_ack", {30'b0, acks}, 32'h1);
    check("stall_lat", lat, 7);
    check("stall_ar_stable", {31'b0, ar_bad}, 32'h0);
    check("stall_addr", last_araddr, 32'hB8);
    check("stall_result0", {26'b0, result0}, 32'd30);
    $display("txn ar-stall: araddr=%0h result0=%0d lat=%0d", last_araddr, result0, lat);

    // read data never arrives
    @(negedge clk);
    r_never = 1;
    a1 = 3'd2; b1 = 3'd2; req1 = 1;
    wait_ack(60, lat, acks);
    req1 = 0;
    check("timeout_ack", {30'b0, acks}, 32'h2);
    check("timeout_lat_window", {31'b0, (lat >= TIMEOUT && lat <= TIMEOUT + 2)}, 32'h1);
    check("timeout_err1", {31'b0, err1}, 32'h1);
    check("timeout_result1", {26'b0, result1}, 32'd0);
    @(negedge clk);
    check("timeout_back_idle", {29'b0, ack1, m_arvalid, m_rready}, 32'h0);
    r_never = 0;
    $display("txn timeout: err1=%0d result1=%0d lat=%0d", err1, result1, lat);

    // reset while waiting for read data
    r_wait = 100;
    a0 = 3'd1; b0 = 3'd1; req0 = 1;
    repeat (2) @(negedge clk);
    check("rst_mid_in_data", {31'b0, m_rready}, 32'h1);
    rst = 0; req0 = 0;
    @(negedge clk);
    rst = 1;
    check("rst_mid_acks", {30'b0, ack1, ack0}, 32'h0);
    check("rst_mid_results", {20'b0, result1, result0}, 32'h0);
    check("rst_mid_errs", {30'b0, err1, err0}, 32'h0);
    check("rst_mid_axi", {30'b0, m_arvalid, m_rready}, 32'h0);
    check("rst_mid_araddr", m_araddr, 32'h0);
    wait_ack(6, lat, acks);
    check("rst_mid_no_ack", lat, -1);
    r_wait = 0;
    a0 = 3'd6; b0 = 3'd7; req0 = 1;
    wait_ack(40, lat, acks);
    req0 = 0;
    check("post_rst_ack", {30'b0, acks}, 32'h1);
    check("post_rst_lat", lat, 3);
    check("post_rst_addr", last_araddr, 32'hDC);
    check("post_rst_result0", {26'b0, result0}, 32'd42);
    check("post_rst_err0", {31'b0, err0}, 32'h0);
    $display("txn post-reset: araddr=%0h result0=%0d lat=%0d", last_araddr, result0, lat);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
